// File: rtl/rsa_keygen_ext.sv
// RSA key generator: n = p*q, phi = (p-1)*(q-1), smallest odd e >= E_START coprime to phi,
// and d = e^-1 mod phi via extended Euclid, using a shared iterative restoring divider.
module rsa_keygen_ext #(
  parameter int PW      = 8,
  parameter int E_START = 3,
  localparam int NW     = 2 * PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] p,
  input  logic [PW-1:0] q,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [NW-1:0] n,
  output logic [NW-1:0] e,
  output logic [NW-1:0] d
);

  localparam int TW = NW + 2;
  localparam int CW = $clog2(NW);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_DIV, S_UPD, S_CHK, S_FIN
  } state_t;

  state_t                state;
  logic [PW-1:0]         p_r, q_r;
  logic [NW-1:0]         phi;
  logic [NW:0]           cand;
  logic [NW-1:0]         old_r, r;
  logic signed [TW-1:0]  old_t, t;
  logic [NW-1:0]         rem, dq;
  logic [CW-1:0]         cnt;

  logic [NW-1:0]         n_c, phi_c;
  logic                  bad_in;
  logic [NW:0]           shifted, diff;
  logic [NW-1:0]         rem_nx, dq_nx;
  logic signed [TW-1:0]  t_new;
  logic [NW:0]           cand_nx;
  logic [NW-1:0]         d_val;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    n_c     = NW'(p_r) * NW'(q_r);
    phi_c   = (NW'(p_r) - NW'(1)) * (NW'(q_r) - NW'(1));
    bad_in  = (p_r < PW'(2)) || (q_r < PW'(2)) || (phi_c <= NW'(E_START));
    // One restoring-division step: shift the next dividend bit in, subtract if it fits.
    shifted = {rem, dq[NW-1]};
    diff    = shifted - {1'b0, r};
    rem_nx  = diff[NW] ? shifted[NW-1:0] : diff[NW-1:0];
    dq_nx   = {dq[NW-2:0], ~diff[NW]};
    // After NW steps dq holds the quotient and rem equals old_r - quot*r.
    t_new   = old_t - $signed({2'b00, dq}) * t;
    cand_nx = cand + (NW+1)'(2);
    d_val   = NW'((old_t < 0) ? old_t + $signed({2'b00, phi}) : old_t);
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      n     <= '0;
      e     <= '0;
      d     <= '0;
      p_r   <= '0;
      q_r   <= '0;
      phi   <= '0;
      cand  <= '0;
      old_r <= '0;
      r     <= '0;
      old_t <= '0;
      t     <= '0;
      rem   <= '0;
      dq    <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          if (start) begin
            p_r   <= p;
            q_r   <= q;
            n     <= '0;
            e     <= '0;
            d     <= '0;
            error <= 1'b0;
            busy  <= 1'b1;
            state <= S_INIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_INIT: begin
          n   <= n_c;
          phi <= phi_c;
          if (bad_in) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            cand  <= (NW+1)'(E_START);
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          old_r <= phi;
          r     <= NW'(cand);
          old_t <= '0;
          t     <= TW'(1);
          rem   <= '0;
          dq    <= phi;
          cnt   <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          rem <= rem_nx;
          dq  <= dq_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NW - 1)) state <= S_UPD;
        end
        S_UPD: begin
          old_r <= r;
          r     <= rem;
          old_t <= t;
          t     <= t_new;
          rem   <= '0;
          dq    <= r;
          cnt   <= '0;
          state <= (rem != '0) ? S_DIV : S_CHK;
        end
        S_CHK: begin
          if (old_r == NW'(1)) begin
            d     <= d_val;
            e     <= NW'(cand);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else if (cand_nx >= {1'b0, phi}) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            cand  <= cand_nx;
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_keygen_ext.sv
// Directed bench for rsa_keygen_ext: hand-computed key pairs, error cases,
// start collisions and asynchronous abort.
module tb_rsa_keygen_ext;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  p, q;
  logic        busy, done, error;
  logic [15:0] n, e, d;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int c0;

  rsa_keygen_ext #(.PW(8), .E_START(3)) dut (
    .clk(clk), .rst_n(rst_n), .p(p), .q(q), .start(start),
    .busy(busy), .done(done), .error(error), .n(n), .e(e), .d(d)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [7:0] pp, input logic [7:0] qq);
    @(negedge clk);
    p = pp;
    q = qq;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 5000 && !done; k++) @(negedge clk);
    check({tag, "_done"}, 32'(done), 1);
  endtask

  task automatic expect_res(input string tag, input int en, input int ee, input int ed,
                            input int eerr);
    check({tag, "_n"}, 32'(n), en);
    check({tag, "_e"}, 32'(e), ee);
    check({tag, "_d"}, 32'(d), ed);
    check({tag, "_error"}, 32'(error), eerr);
    check({tag, "_busy_lo"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    p = '0;
    q = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_n", 32'(n), 0);
    check("rst_e", 32'(e), 0);
    check("rst_d", 32'(d), 0);
    rst_n = 1'b1;

    // Smallest case: phi=20, e=3, d=7
    c0 = done_cnt;
    launch(8'd3, 8'd11);
    check("t1_busy_hi", 32'(busy), 1);
    wait_done("t1");
    expect_res("t1", 33, 3, 7, 0);
    @(negedge clk);
    check("t1_pulse_end", 32'(done), 0);
    check("t1_n_held", 32'(n), 33);
    check("t1_d_held", 32'(d), 7);
    check("t1_one_pulse", 32'(done_cnt - c0), 1);

    // phi=3120: 3 and 5 divide it, e=7, d=1783
    launch(8'd61, 8'd53);
    wait_done("t2");
    expect_res("t2", 3233, 7, 1783, 0);

    // phi=2 <= E_START
    launch(8'd2, 8'd3);
    wait_done("t3");
    expect_res("t3", 6, 0, 0, 1);

    // p < 2
    launch(8'd1, 8'd7);
    wait_done("t4");
    expect_res("t4", 7, 0, 0, 1);
    @(negedge clk);
    check("t4_busy_after", 32'(busy), 0);
    check("t4_error_held", 32'(error), 1);

    // Start while busy is ignored; start in the FIN cycle is accepted
    c0 = done_cnt;
    launch(8'd61, 8'd53);
    repeat (5) @(negedge clk);
    p = 8'd3;
    q = 8'd11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5a");
    expect_res("t5a", 3233, 7, 1783, 0);
    p = 8'd5;
    q = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5b_busy_hi", 32'(busy), 1);
    check("t5b_cleared_n", 32'(n), 0);
    wait_done("t5b");
    expect_res("t5b", 35, 5, 5, 0);
    @(negedge clk);
    check("t5_two_pulses", 32'(done_cnt - c0), 2);

    // Asynchronous reset in the middle of a division
    launch(8'd61, 8'd53);
    repeat (4) @(negedge clk);
    c0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_error", 32'(error), 0);
    check("t6_rst_n", 32'(n), 0);
    check("t6_rst_e", 32'(e), 0);
    check("t6_rst_d", 32'(d), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t6_no_pulse", 32'(done_cnt - c0), 0);
    check("t6_idle", 32'(busy), 0);
    launch(8'd5, 8'd7);
    wait_done("t6");
    expect_res("t6", 35, 5, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_keygen_ext.md
Name: rsa_keygen_ext

Overview:
- Parametrised successor to the server-side RSA key generator.
- From primes p, q it computes n = p*q and phi = (p-1)*(q-1).
- It searches odd candidates e upward from E_START for gcd(e, phi) == 1, then produces the private exponent d = e^-1 mod phi using the extended Euclidean algorithm.
- Division is done by an internal iterative restoring divider, so there are no combinational % or / operators. The block sits between the prime-input stage and the encrypt/decrypt datapaths.

Parameters:
- PW, 8: width of p and q. Modulus and phi are NW = 2*PW bits.
- E_START, 3: first candidate e. Must be odd and >= 3.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- p  in  PW  prime p, sampled on accepted start
- q  in  PW  prime q, sampled on accepted start
- start  in  1  request pulse; accepted only when busy==0
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse at end of operation (success or error)
- error  out  1  held with done result: bad inputs or no e found
- n  out  NW  p*q, held until next accepted start
- e  out  NW  public exponent, held
- d  out  NW  private exponent in [1, phi-1], held

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. busy, done, error, n, e and d are all 0. Reset mid-operation aborts immediately with no done pulse.
- Start acceptance: start is accepted when in IDLE or DONE. p and q are registered. n, e, d and error are cleared to 0 and busy=1 next cycle. start while busy is ignored.
- FSM states: IDLE -> INIT -> LOAD -> DIV -> UPD -> (DIV | CHK) -> (LOAD | FIN) -> IDLE.
- INIT: compute n and phi in NW-bit unsigned arithmetic.
  - If p<2, q<2, or phi <= E_START: error=1, go to FIN.
  - Otherwise cand = E_START.
- LOAD:
  - old_r = phi, r = cand, old_t = 0, t = 1.
  - t and old_t are signed, NW+2 bits.
- DIV: restoring division quot = old_r / r, one quotient bit per cycle, exactly NW cycles.
- UPD (1 cycle):
  - (old_r, r) <= (r, old_r - quot*r)
  - (old_t, t) <= (t, old_t - quot*t)
  - If the new r != 0, go to DIV; else go to CHK.
- CHK (gcd = old_r):
  - If gcd==1: d = old_t if old_t >= 0, else old_t + phi; e = cand; go to FIN.
  - Otherwise cand += 2. If cand >= phi: error=1, go to FIN. Else go to LOAD.
- FIN: done=1 for exactly one cycle and busy=0 in the same cycle. Outputs are valid from this cycle and held. On error, e=d=0 and n is still valid.
- Arithmetic:
  - quot*r and quot*t are truncated to NW and NW+2 bits respectively.
  - |t| <= phi is guaranteed, so no overflow occurs.
  - cand is NW+1 bits so that +2 cannot wrap.
- Latency: per Euclid step NW+1 cycles; per candidate +1 (LOAD) +1 (CHK). No fixed total; bench waits on done.
- Simultaneous events: start asserted in the FIN cycle is accepted (FIN counts as DONE). done still pulses for the finishing operation.

Test Plan:
- p=3, q=11, E_START=3 -> n=33, e=3, d=7, error=0, single done pulse.
- p=61, q=53 -> n=3233; candidates 3 and 5 rejected; e=7, d=1783, error=0.
- p=2, q=3 (phi=2 <= E_START) -> done with error=1, n=6, e=0, d=0.
- p=1, q=7 -> error=1, done pulse, busy low afterwards.
- Start pulsed again while busy with different p/q -> ignored; result matches the first inputs. A new start in the FIN cycle gives a second correct result.
- rst_n low mid-DIV -> all outputs 0 asynchronously and no done pulse. A subsequent start with p=5, q=7 gives n=35, e=5, d=5.
